// File: rtl/sop_sweep_check.sv
// Exhaustive truth-table checker: walks every input vector of an external
// combinational function, compares its output against a latched minterm mask.
module sop_sweep_check #(
    parameter int N    = 3,
    parameter int HOLD = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [(1<<N)-1:0]   mask,
    input  logic                dut_y,
    output logic [N-1:0]        vec,
    output logic                vec_valid,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N:0]          err_cnt,
    output logic [N-1:0]        first_err,
    output logic                first_err_valid
);

    localparam int             NV       = 1 << N;
    localparam int             HOLD_W   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [N-1:0]   LAST_VEC = {N{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [NV-1:0]       mask_q;
    logic [N-1:0]        vec_q;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                sample;
    logic                last_vec;
    logic                mismatch;
    logic [N:0]          err_next;

    // Sample strobe fires on the edge that ends the hold window of the current vector.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_next = state;
        sample     = (state == RUN) && (hold_cnt == HOLD_LAST);
        last_vec   = (vec_q == LAST_VEC);
        mismatch   = sample && (dut_y != mask_q[vec_q]);
        err_next   = err_cnt + {{N{1'b0}}, mismatch};

        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (sample && last_vec) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: registered state uses non-blocking assignment so all flops update together.
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the latched mask is a plain register bank, so clearing it on reset is cheap and keeps it deterministic.
            mask_q          <= '0;
            vec_q           <= '0;
            hold_cnt        <= '0;
            err_cnt         <= '0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q          <= mask;
                        vec_q           <= '0;
                        hold_cnt        <= '0;
                        err_cnt         <= '0;
                        first_err       <= '0;
                        first_err_valid <= 1'b0;
                        pass            <= 1'b0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        hold_cnt <= '0;
                        err_cnt  <= err_next;
                        if (mismatch && !first_err_valid) begin
                            first_err       <= vec_q;
                            first_err_valid <= 1'b1;
                        end
                        if (last_vec) begin
                            vec_q <= '0;
                            // Verdict includes the final vector's result via err_next.
                            pass  <= (err_next == '0);
                        end else begin
                            vec_q <= vec_q + N'(1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign vec       = vec_q;
    assign vec_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_sop_sweep_check.sv
// Bench for sop_sweep_check: table-driven and randomized sweeps on N=3/HOLD=2,
// plus a N=4/HOLD=1 instance, mid-sweep restart/mask change and reset abort.
module tb_sop_sweep_check;

    logic        clk;
    logic        rst_n;

    // N=3, HOLD=2 instance
    logic        start0;
    logic [7:0]  mask0;
    logic [7:0]  fn0;
    logic        dut_y0;
    logic [2:0]  vec0;
    logic        vv0, busy0, done0, pass0, fev0;
    logic [3:0]  err0;
    logic [2:0]  first0;

    // N=4, HOLD=1 instance
    logic        start1;
    logic [15:0] mask1;
    logic        dut_y1;
    logic [3:0]  vec1;
    logic        vv1, busy1, done1, pass1, fev1;
    logic [4:0]  err1;
    logic [3:0]  first1;

    int checks = 0;
    int errors = 0;

    assign dut_y0 = fn0[vec0];
    assign dut_y1 = &vec1;

    sop_sweep_check #(.N(3), .HOLD(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mask(mask0), .dut_y(dut_y0),
        .vec(vec0), .vec_valid(vv0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_err(first0), .first_err_valid(fev0)
    );

    sop_sweep_check #(.N(4), .HOLD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mask(mask1), .dut_y(dut_y1),
        .vec(vec1), .vec_valid(vv1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_err(first1), .first_err_valid(fev1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] fn;
        int         err;
        int         first;
        bit         fv;
        bit         pass;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: mismatches are the bits where mask and the function's truth table differ.
    task automatic model(input logic [7:0] m, input logic [7:0] f,
                         output int err, output int first, output bit fv);
        err = 0; first = 0; fv = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i] !== f[i]) begin
                if (!fv) begin
                    first = i;
                    fv    = 1;
                end
                err++;
            end
        end
    endtask

    // One sweep on the N=3 instance. At cycle repulse_at, start is pulsed again and
    // mask switched to alt_mask; neither may influence the sweep.
    task automatic run_sweep(input string name, input logic [7:0] m, input logic [7:0] f,
                             input int e_err, input int e_first, input bit e_fv, input bit e_pass,
                             input int repulse_at, input logic [7:0] alt_mask);
        int extra_done;
        @(negedge clk);
        mask0  = m;
        fn0    = f;
        start0 = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            start0 = (j == repulse_at);
            if (j == repulse_at) mask0 = alt_mask;
            check({name, "_run"}, {25'd0, busy0, vv0, done0, pass0, vec0},
                  {25'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(j / 2)});
        end
        @(negedge clk);
        start0 = 1'b0;
        check({name, "_done"}, {23'd0, done0, busy0, vv0, vec0}, {23'd0, 1'b1, 1'b0, 1'b0, 3'd0});
        check({name, "_err"}, {28'd0, err0}, 32'(e_err));
        check({name, "_first"}, {28'd0, fev0, first0}, {28'd0, e_fv, 3'(e_first)});
        check({name, "_pass"}, {31'd0, pass0}, {31'd0, e_pass});
        extra_done = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (done0 || busy0) extra_done++;
        end
        check({name, "_no_extra"}, 32'(extra_done), 32'd0);
        check({name, "_hold"}, {24'd0, pass0, err0, fev0, first0[1:0]},
              {24'd0, e_pass, 4'(e_err), e_fv, 2'(e_first)});
    endtask

    initial begin
        vec_t tbl[6];
        int   e_err, e_first, c, dones;
        bit   e_fv;
        logic [7:0] m, f;

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        mask0  = 8'h00;
        fn0    = 8'h00;
        mask1  = 16'h0000;
        #1;
        check("reset_state0", {17'd0, vec0, vv0, busy0, done0, pass0, err0, first0, fev0}, 32'd0);
        check("reset_state1", {14'd0, vec1, vv1, busy1, done1, pass1, err1, first1, fev1}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{mask: 8'hE8, fn: 8'hE8, err: 0, first: 0, fv: 0, pass: 1}; // majority
        tbl[1] = '{mask: 8'hE8, fn: 8'h00, err: 4, first: 3, fv: 1, pass: 0};
        tbl[2] = '{mask: 8'h00, fn: 8'hFF, err: 8, first: 0, fv: 1, pass: 0}; // no wrap
        tbl[3] = '{mask: 8'h80, fn: 8'h00, err: 1, first: 7, fv: 1, pass: 0}; // last vector only
        tbl[4] = '{mask: 8'h0F, fn: 8'h1F, err: 1, first: 4, fv: 1, pass: 0};
        tbl[5] = '{mask: 8'h5A, fn: 8'hA5, err: 8, first: 0, fv: 1, pass: 0};
        for (int i = 0; i < 6; i++)
            run_sweep($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].fn, tbl[i].err,
                      tbl[i].first, tbl[i].fv, tbl[i].pass, -1, 8'h00);

        // Restart attempt and mask change mid-sweep: results follow the original mask.
        run_sweep("repulse", 8'hE8, 8'h00, 4, 3, 1, 0, 5, 8'h00);

        // Randomized sweeps against the reference model.
        for (int i = 0; i < 8; i++) begin
            m = 8'($urandom);
            f = (i % 3 == 0) ? m : 8'($urandom);
            model(m, f, e_err, e_first, e_fv);
            run_sweep($sformatf("rand%0d", i), m, f, e_err, e_first, e_fv, (e_err == 0), -1, 8'h00);
        end

        // Reset while vec=4: outputs clear before the next edge, no done afterwards.
        @(negedge clk);
        mask0  = 8'hE8;
        fn0    = 8'h00;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_vec4", {29'd0, vec0}, 32'd4);
        #1 rst_n = 1'b0;
        #1;
        check("abort_clear", {17'd0, vec0, vv0, busy0, done0, pass0, err0, first0, fev0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (done0 || busy0) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_sweep("after_abort", 8'hE8, 8'hE8, 0, 0, 0, 1, -1, 8'h00);

        // N=4, HOLD=1: AND function against minterm 15 only.
        @(negedge clk);
        mask1  = 16'h8000;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        c = 0;
        while (!done1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("n4_latency", 32'(c), 32'd16);
        check("n4_pass", {31'd0, pass1}, 32'd1);
        check("n4_err", {22'd0, err1, fev1, first1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sop_sweep_check.md
SOP_SWEEP_CHECK -- requirements
Module: sop_sweep_check

Interface
REQ-001 The block SHALL have parameter N, default 3: number of function inputs; legal range 1..8.
REQ-002 The block SHALL have parameter HOLD, default 1: clock cycles each input vector is held; legal range >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: requests one exhaustive sweep.
REQ-006 The block SHALL have port mask, input, 2^N bits: expected truth table; bit i is the expected y for input vector i (minterm mask of the SOP).
REQ-007 The block SHALL have port dut_y, input, 1 bit: output of the external combinational function under test.
REQ-008 The block SHALL have port vec, output, N bits: input vector driven to the function under test.
REQ-009 The block SHALL have port vec_valid, output, 1 bit: vec is an active test vector.
REQ-010 The block SHALL have port busy, output, 1 bit: sweep in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse marking sweep completion.
REQ-012 The block SHALL have port pass, output, 1 bit: last completed sweep had zero mismatches.
REQ-013 The block SHALL have port err_cnt, output, N+1 bits: mismatch count of the current or last sweep.
REQ-014 The block SHALL have port first_err, output, N bits: lowest vector index that mismatched.
REQ-015 The block SHALL have port first_err_valid, output, 1 bit: first_err holds a captured index.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE, with transitions IDLE->RUN on start, RUN->DONE after the last sample, and DONE->IDLE unconditionally after one cycle.
REQ-017 On a clock edge where start=1 in IDLE, the block SHALL latch mask internally, set err_cnt=0, first_err=0, first_err_valid=0 and pass=0, drive vec=0, set vec_valid=1 and busy=1.
REQ-018 Vector v SHALL be driven from edge k+v*HOLD until edge k+(v+1)*HOLD, where k is the start edge.
REQ-019 At edge k+(v+1)*HOLD the block SHALL sample dut_y for vector v; a mismatch is dut_y != mask_latched[v].
REQ-020 On a mismatch the block SHALL increment err_cnt by 1; err_cnt SHALL never wrap because its N+1-bit width holds a count of 2^N.
REQ-021 On the first mismatch of a sweep the block SHALL set first_err=v and first_err_valid=1; later mismatches SHALL leave first_err unchanged.
REQ-022 At the sample edge of vector 2^N-1 (edge k+2^N*HOLD) the block SHALL enter DONE with done=1, busy=0, vec_valid=0, vec=0, and pass=1 exactly when the final err_cnt is 0, including the last vector's result.
REQ-023 Total sweep latency SHALL be 2^N*HOLD cycles from the start edge to done asserting.
REQ-024 done SHALL be high for exactly one cycle and the block SHALL then return to IDLE.
REQ-025 start SHALL be ignored in RUN and DONE, with no restart or extension of the sweep.
REQ-026 Changes on mask after the start edge SHALL have no effect on the sweep in progress.
REQ-027 pass, err_cnt, first_err and first_err_valid SHALL hold their values in IDLE until the next accepted start.
REQ-028 While busy, pass SHALL read 0.

Reset
REQ-029 When rst_n=0 the block SHALL immediately (asynchronously) force state=IDLE and vec=0, vec_valid=0, busy=0, done=0, pass=0, err_cnt=0, first_err=0, first_err_valid=0, and clear the latched mask.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; after rst_n rises, the first start edge SHALL run a complete sweep from vector 0.

Verification (N=3, HOLD=2 unless stated)
REQ-031 The bench SHALL check: mask=8'hE8 with dut_y a majority function of vec -> vec steps 0..7 with 2 cycles each, done 16 cycles after the start edge, pass=1, err_cnt=0, first_err_valid=0.
REQ-032 The bench SHALL check: mask=8'hE8 with dut_y tied 0 -> err_cnt=4, first_err=3, first_err_valid=1, pass=0.
REQ-033 The bench SHALL check: mask=8'h00 with dut_y tied 1 -> err_cnt=8 (4'b1000, no wrap), first_err=0, pass=0.
REQ-034 The bench SHALL check: start re-pulsed 5 cycles into a sweep and mask changed mid-sweep -> a single done at cycle 16 and results per the originally latched mask.
REQ-035 The bench SHALL check: rst_n pulsed low while vec=4 -> all outputs 0 before the next clock edge and no done; the following start yields a full 16-cycle sweep.
REQ-036 The bench SHALL check: N=4, HOLD=1, mask=16'h8000 with dut_y equal to the AND of all vec bits -> done 16 cycles after start, pass=1.
